seq_debug_cmd_mailbox: RTL and testbench
========================================

SEQ_DEBUG_CMD_MAILBOX -- requirements
Module: seq_debug_cmd_mailbox

Interface
REQ-001 The block SHALL have a parameter BASE_ADDR, default 'h00015240, giving the byte address of the REQ_CMD register.
REQ-002 The block SHALL have a parameter ADDR_WIDTH, default 20, giving the Avalon byte-address width.
REQ-003 The block SHALL have a parameter NUM_PARAMS, default 4, giving the number of 32-bit parameter words.
REQ-004 The block SHALL have port avl_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port avl_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port avl_address, input, ADDR_WIDTH bits: byte address, word-aligned.
REQ-007 The block SHALL have ports avl_write and avl_read, input, 1 bit each: access strobes, at most one per cycle.
REQ-008 The block SHALL have port avl_writedata, input, 32 bits: write data.
REQ-009 The block SHALL have ports avl_readdata (output, 32 bits) and avl_readdatavalid (output, 1 bit): read response.
REQ-010 The block SHALL have port cmd_valid, output, 1 bit: a command is offered to the sequencer core.
REQ-011 The block SHALL have port cmd_ready, input, 1 bit: the core accepts the command.
REQ-012 The block SHALL have ports cmd_code (output, 32 bits) and cmd_params (output, 32*NUM_PARAMS bits): the command word and packed parameters, word 0 in the LSBs.
REQ-013 The block SHALL have ports done_valid (input, 1 bit) and done_result (input, 8 bits): the single-cycle completion pulse and result code.

Function
REQ-014 Register map, byte offsets from BASE_ADDR: 0x0 REQ_CMD, 0x4 CMD_STATUS, 0x8+4*i PARAM[i] for i = 0..NUM_PARAMS-1.
REQ-015 Addresses outside the map SHALL read 0 and ignore writes.
REQ-016 Reads SHALL have fixed latency 1: avl_readdatavalid high exactly one cycle after avl_read, with avl_readdata valid in that cycle; avl_readdatavalid low otherwise.
REQ-017 FSM states: IDLE(0), PENDING(1), BUSY(2), DONE(3).
REQ-018 In IDLE, a write to REQ_CMD SHALL latch cmd_code and go to PENDING on the next cycle.
REQ-019 In PENDING, cmd_valid SHALL be high; on cmd_valid&&cmd_ready the state SHALL go to BUSY and cmd_valid SHALL drop the next cycle.
REQ-020 cmd_code and cmd_params SHALL remain stable from entry to PENDING until the state returns to IDLE.
REQ-021 In BUSY, done_valid SHALL latch done_result and go to DONE; done_valid in any other state SHALL be ignored.
REQ-022 In DONE, a CMD_STATUS write with bit0=1 SHALL clear the state to IDLE; all other CMD_STATUS writes SHALL be ignored.
REQ-023 PARAM writes SHALL take effect only in IDLE.
REQ-024 Any REQ_CMD or PARAM write outside IDLE SHALL be dropped and SHALL set the sticky reject flag.
REQ-025 The reject flag SHALL be cleared only by a CMD_STATUS write with bit16=1, in any state; such a write SHALL leave the FSM unchanged unless REQ-022 also applies.
REQ-026 CMD_STATUS readback SHALL be: [1:0] state, [15:8] latched result, [16] reject, all other bits 0.
REQ-027 REQ_CMD and PARAM[i] SHALL read back their latched values.
REQ-028 A read and a state change in the same cycle SHALL return the pre-edge register values.

Reset
REQ-029 On avl_reset_n low, the block SHALL asynchronously reach IDLE with cmd_valid=0, avl_readdatavalid=0, avl_readdata=0, cmd_code=0, all params=0, result=0, and reject=0.
REQ-030 Reset asserted in PENDING or BUSY SHALL abandon the command with no completion recorded.
REQ-031 Reset release SHALL be synchronous to avl_clk.

Verification
REQ-032 The bench SHALL cover write PARAM0='hA5, then REQ_CMD='h3 -> next cycle cmd_valid=1, cmd_code=3, cmd_params[31:0]='hA5, and a STATUS read returns 'h1.
REQ-033 The bench SHALL cover cmd_ready held low 10 cycles, then pulsed -> cmd_valid stays high for all 11 cycles, drops after the handshake, and STATUS returns 'h2.
REQ-034 The bench SHALL cover done_valid with result 'h7E in BUSY -> STATUS='h7E03; a STATUS write of 'h1 -> STATUS='h7E00.
REQ-035 The bench SHALL cover a REQ_CMD write of 'h9 in BUSY -> cmd_code unchanged and STATUS bit16=1; a STATUS write of 'h10000 -> bit16=0 with the state still BUSY.
REQ-036 The bench SHALL cover done_valid in IDLE and a read at BASE_ADDR+'h40 -> no state change, and readdata=0 with readdatavalid asserted one cycle after the read.
REQ-037 The bench SHALL cover avl_reset_n asserted mid-PENDING -> cmd_valid=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/seq_debug_cmd_mailbox.sv
// Debug command mailbox: Avalon-MM register file feeding a
// valid/ready command port, with completion capture and reject flag.
module seq_debug_cmd_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h00015240,
    parameter int          ADDR_WIDTH = 20,
    parameter int          NUM_PARAMS = 4
) (
    input  logic                    avl_clk,
    input  logic                    avl_reset_n,
    input  logic [ADDR_WIDTH-1:0]   avl_address,
    input  logic                    avl_write,
    input  logic                    avl_read,
    input  logic [31:0]             avl_writedata,
    output logic [31:0]             avl_readdata,
    output logic                    avl_readdatavalid,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [31:0]             cmd_code,
    output logic [32*NUM_PARAMS-1:0] cmd_params,
    input  logic                    done_valid,
    input  logic [7:0]              done_result
);

    localparam int LP_WW = ADDR_WIDTH - 2;
    localparam logic [ADDR_WIDTH-1:0] LP_BASE =
        BASE_ADDR[ADDR_WIDTH-1:0];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PENDING = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]              r_rst_sync;
    logic                    w_rst_n;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [31:0]             r_cmd_code;
    logic [31:0]             r_params [NUM_PARAMS];
    logic [7:0]              r_result;
    logic                    r_reject;
    logic [31:0]             r_rdata;
    logic                    r_rvalid;

    logic [ADDR_WIDTH-1:0]   w_off;
    logic [LP_WW-1:0]        w_word;
    logic                    w_aligned;
    logic                    w_sel_cmd;
    logic                    w_sel_sts;
    logic [NUM_PARAMS-1:0]   w_psel;
    logic                    w_wr_cmd;
    logic                    w_wr_sts;
    logic                    w_wr_prm;
    logic                    w_idle;
    logic [31:0]             w_status;
    logic [31:0]             w_rmux;

    // Reset asserts immediately, releases on a clock edge.
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Address decode relative to the mailbox base.
    assign w_off     = avl_address - LP_BASE;
    assign w_word    = w_off[ADDR_WIDTH-1:2];
    assign w_aligned = (w_off[1:0] == 2'b00);
    assign w_sel_cmd = w_aligned && (w_word == LP_WW'(0));
    assign w_sel_sts = w_aligned && (w_word == LP_WW'(1));

    // One select line per parameter word.
    always_comb begin
        w_psel = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            w_psel[i] = w_aligned && (w_word == LP_WW'(i + 2));
        end
    end

    assign w_wr_cmd = avl_write && w_sel_cmd;
    assign w_wr_sts = avl_write && w_sel_sts;
    assign w_wr_prm = avl_write && (|w_psel);
    assign w_idle   = (r_state == S_IDLE);

    // FSM state register.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_wr_cmd) w_state_nxt = S_PENDING;
            end
            S_PENDING: begin
                if (cmd_ready) w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (done_valid) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (w_wr_sts && avl_writedata[0]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: command offer and frozen command payload.
    always_comb begin
        cmd_valid  = (r_state == S_PENDING);
        cmd_code   = r_cmd_code;
        cmd_params = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            cmd_params[32*i +: 32] = r_params[i];
        end
    end

    // Command word is only accepted while idle.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cmd_code <= '0;
        end else if (w_wr_cmd && w_idle) begin
            r_cmd_code <= avl_writedata;
        end
    end

    // Parameter words are only accepted while idle.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_params[i] <= '0;
            end
        end else if (avl_write && w_idle) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                if (w_psel[i]) r_params[i] <= avl_writedata;
            end
        end
    end

    // Completion code captured only while the core is busy.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_result <= '0;
        end else if ((r_state == S_BUSY) && done_valid) begin
            r_result <= done_result;
        end
    end

    // Sticky flag for command/param writes that arrive too late.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_reject <= 1'b0;
        end else if (w_wr_sts && avl_writedata[16]) begin
            r_reject <= 1'b0;
        end else if ((w_wr_cmd || w_wr_prm) && !w_idle) begin
            r_reject <= 1'b1;
        end
    end

    assign w_status = {15'd0, r_reject, r_result, 6'd0, r_state};

    // Read mux over current (pre-edge) register values.
    always_comb begin
        w_rmux = '0;
        unique case (1'b1)
            w_sel_cmd: w_rmux = r_cmd_code;
            w_sel_sts: w_rmux = w_status;
            default:   w_rmux = '0;
        endcase
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (w_psel[i]) w_rmux = r_params[i];
        end
    end

    // Single-cycle read response pipeline.
    always_ff @(posedge avl_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= avl_read;
            r_rdata  <= avl_read ? w_rmux : 32'd0;
        end
    end

    assign avl_readdata      = r_rdata;
    assign avl_readdatavalid = r_rvalid;

endmodule

// File: tb/tb_seq_debug_cmd_mailbox.sv
// Bench for seq_debug_cmd_mailbox: directed scenarios plus random
// traffic checked every cycle against a transaction-level model.
module tb_seq_debug_cmd_mailbox;

    localparam int NP   = 4;
    localparam int AW   = 20;
    localparam int BASE = 'h15240;

    logic              avl_clk = 1'b0;
    logic              avl_reset_n = 1'b0;
    logic [AW-1:0]     avl_address = '0;
    logic              avl_write = 1'b0;
    logic              avl_read = 1'b0;
    logic [31:0]       avl_writedata = '0;
    logic [31:0]       avl_readdata;
    logic              avl_readdatavalid;
    logic              cmd_valid;
    logic              cmd_ready = 1'b0;
    logic [31:0]       cmd_code;
    logic [32*NP-1:0]  cmd_params;
    logic              done_valid = 1'b0;
    logic [7:0]        done_result = '0;

    int n_tests = 0;
    int n_fail  = 0;

    seq_debug_cmd_mailbox #(
        .BASE_ADDR (32'h00015240),
        .ADDR_WIDTH(AW),
        .NUM_PARAMS(NP)
    ) dut (
        .avl_clk          (avl_clk),
        .avl_reset_n      (avl_reset_n),
        .avl_address      (avl_address),
        .avl_write        (avl_write),
        .avl_read         (avl_read),
        .avl_writedata    (avl_writedata),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_code         (cmd_code),
        .cmd_params       (cmd_params),
        .done_valid       (done_valid),
        .done_result      (done_result)
    );

    initial forever #5 avl_clk = ~avl_clk;

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // state: 0 idle, 1 command offered, 2 core working, 3 finished
    int          m_state;
    logic [31:0] m_code;
    logic [31:0] m_params [NP];
    logic [7:0]  m_res;
    logic        m_rej;
    logic        m_rv;
    logic [31:0] m_rd;

    // 0 unmapped, 1 REQ_CMD, 2 CMD_STATUS, 3+i PARAM[i]
    function automatic int kind(input logic [AW-1:0] a);
        int off;
        off = int'(a) - BASE;
        if (off == 0) return 1;
        if (off == 4) return 2;
        if (off >= 8 && off < 8 + 4*NP && off % 4 == 0)
            return 3 + (off - 8) / 4;
        return 0;
    endfunction

    function automatic logic [31:0] mread(input logic [AW-1:0] a);
        int k;
        logic [31:0] st;
        k = kind(a);
        st = 32'd0;
        st[1:0] = 2'(m_state);
        st[15:8] = m_res;
        st[16] = m_rej;
        if (k == 1) return m_code;
        if (k == 2) return st;
        if (k >= 3) return m_params[k-3];
        return 32'd0;
    endfunction

    always @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            m_state <= 0;
            m_code  <= '0;
            for (int i = 0; i < NP; i++) m_params[i] <= '0;
            m_res   <= '0;
            m_rej   <= 1'b0;
            m_rv    <= 1'b0;
            m_rd    <= '0;
        end else begin
            m_rv <= avl_read;
            m_rd <= avl_read ? mread(avl_address) : 32'd0;
            if (avl_write) begin
                if (kind(avl_address) == 1) begin
                    if (m_state == 0) begin
                        m_code  <= avl_writedata;
                        m_state <= 1;
                    end else m_rej <= 1'b1;
                end else if (kind(avl_address) == 2) begin
                    if (avl_writedata[16]) m_rej <= 1'b0;
                    if (m_state == 3 && avl_writedata[0]) m_state <= 0;
                end else if (kind(avl_address) >= 3) begin
                    if (m_state == 0)
                        m_params[kind(avl_address)-3] <= avl_writedata;
                    else m_rej <= 1'b1;
                end
            end
            if (m_state == 1 && cmd_ready) m_state <= 2;
            if (m_state == 2 && done_valid) begin
                m_res   <= done_result;
                m_state <= 3;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge avl_clk) begin
        chk("cmd_valid", 128'(cmd_valid), 128'(m_state == 1));
        chk("cmd_code", 128'(cmd_code), 128'(m_code));
        chk("cmd_params", 128'(cmd_params),
            {m_params[3], m_params[2], m_params[1], m_params[0]});
        chk("readdatavalid", 128'(avl_readdatavalid), 128'(m_rv));
        if (m_rv) chk("readdata", 128'(avl_readdata), 128'(m_rd));
    end

    // ---------------- bus helpers ----------------
    task automatic tick();
        @(posedge avl_clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        avl_address   = AW'(a);
        avl_writedata = d;
        avl_write     = 1'b1;
        tick();
        avl_write     = 1'b0;
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        avl_address = AW'(a);
        avl_read    = 1'b1;
        tick();
        avl_read    = 1'b0;
        chk("rd_valid_latency", 128'(avl_readdatavalid), 128'(1));
        d = avl_readdata;
    endtask

    task automatic rand_phase(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            avl_address   = AW'(BASE - 8 + 4 * $urandom_range(0, 11));
            avl_writedata = $urandom;
            avl_write     = (r < 3);
            avl_read      = (r >= 3 && r < 6);
            cmd_ready     = ($urandom_range(0, 3) == 0);
            done_valid    = ($urandom_range(0, 4) == 0);
            done_result   = 8'($urandom);
            tick();
        end
        avl_write  = 1'b0;
        avl_read   = 1'b0;
        cmd_ready  = 1'b0;
        done_valid = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] d;
        repeat (3) @(posedge avl_clk);
        #1;
        chk("rst_cmd_valid", 128'(cmd_valid), 128'(0));
        chk("rst_rvalid", 128'(avl_readdatavalid), 128'(0));
        chk("rst_rdata", 128'(avl_readdata), 128'(0));
        chk("rst_cmd_code", 128'(cmd_code), 128'(0));
        chk("rst_params", 128'(cmd_params), 128'(0));
        avl_reset_n = 1'b1;
        repeat (3) tick();

        wr(BASE + 8, 32'hA5);
        wr(BASE, 32'h3);
        chk("pend_valid", 128'(cmd_valid), 128'(1));
        chk("pend_code", 128'(cmd_code), 128'(3));
        chk("pend_p0", 128'(cmd_params[31:0]), 128'('hA5));
        rd(BASE + 4, d);
        chk("status_pending", 128'(d), 128'('h1));

        for (int i = 0; i < 10; i++) begin
            chk("valid_held", 128'(cmd_valid), 128'(1));
            tick();
        end
        cmd_ready = 1'b1;
        chk("valid_at_hs", 128'(cmd_valid), 128'(1));
        tick();
        cmd_ready = 1'b0;
        chk("valid_dropped", 128'(cmd_valid), 128'(0));
        rd(BASE + 4, d);
        chk("status_busy", 128'(d), 128'('h2));

        wr(BASE, 32'h9);
        chk("code_kept", 128'(cmd_code), 128'(3));
        rd(BASE + 4, d);
        chk("status_reject", 128'(d), 128'('h10002));
        wr(BASE + 4, 32'h10000);
        rd(BASE + 4, d);
        chk("status_rej_clr", 128'(d), 128'('h2));

        done_valid  = 1'b1;
        done_result = 8'h7E;
        tick();
        done_valid  = 1'b0;
        rd(BASE + 4, d);
        chk("status_done", 128'(d), 128'('h7E03));
        wr(BASE + 4, 32'h1);
        rd(BASE + 4, d);
        chk("status_ack", 128'(d), 128'('h7E00));

        done_valid  = 1'b1;
        done_result = 8'h55;
        tick();
        done_valid  = 1'b0;
        rd(BASE + 4, d);
        chk("idle_done_ign", 128'(d), 128'('h7E00));
        wr(BASE + 'h40, 32'hFFFF);
        rd(BASE + 'h40, d);
        chk("unmapped_rd", 128'(d), 128'(0));
        wr(BASE + 'h14, 32'h1234);
        rd(BASE + 'h14, d);
        chk("param3_rb", 128'(d), 128'('h1234));
        rd(BASE, d);
        chk("cmd_rb", 128'(d), 128'('h3));

        wr(BASE, 32'h5);
        chk("pend2_valid", 128'(cmd_valid), 128'(1));
        #3;
        avl_reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 128'(cmd_valid), 128'(0));
        chk("async_rst_code", 128'(cmd_code), 128'(0));
        chk("async_rst_params", 128'(cmd_params), 128'(0));
        repeat (2) @(posedge avl_clk);
        #1;
        avl_reset_n = 1'b1;
        repeat (3) tick();
        rd(BASE + 4, d);
        chk("status_after_rst", 128'(d), 128'(0));

        rand_phase(1500);
        #3;
        avl_reset_n = 1'b0;
        repeat (2) @(posedge avl_clk);
        #1;
        avl_reset_n = 1'b1;
        repeat (3) tick();
        rand_phase(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
